// File: rtl/fetch_bundle_queue_if.sv
// Fetch-to-decode bundle link: fetch-side bundle bus, decode-side handshake and queue status.
// Latency: none, wires only.
// Backpressure: stall_fetch toward fetch, dec_ready from decode.
// Ports: fetch_vld / *_from_fetch / has_mispredict / dec_ready flow into the queue;
//        stall_fetch, bundle and lane valids, *_to_dec, occupancy and overflow_err flow out.
// modport slave is the queue side, modport master is the fetch/decode/ROB side.
interface fetch_bundle_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 16
);
  localparam int LW = 4 * PC_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fetch_vld;
  logic [LW-1:0] pc_from_fetch;
  logic [LW-1:0] inst_from_fetch;
  logic [LW-1:0] recv_pc_from_fetch;
  logic [3:0]    pred_from_fetch;
  logic          has_mispredict;
  logic          dec_ready;

  logic          stall_fetch;
  logic          bundle_vld_to_dec;
  logic [LW-1:0] pc_to_dec;
  logic [LW-1:0] inst_to_dec;
  logic [LW-1:0] recv_pc_to_dec;
  logic [3:0]    pred_to_dec;
  logic [3:0]    lane_vld_to_dec;
  logic [CW-1:0] occupancy;
  logic          overflow_err;

  modport slave (
    input  fetch_vld, pc_from_fetch, inst_from_fetch, recv_pc_from_fetch,
           pred_from_fetch, has_mispredict, dec_ready,
    output stall_fetch, bundle_vld_to_dec, pc_to_dec, inst_to_dec,
           recv_pc_to_dec, pred_to_dec, lane_vld_to_dec, occupancy, overflow_err
  );

  modport master (
    output fetch_vld, pc_from_fetch, inst_from_fetch, recv_pc_from_fetch,
           pred_from_fetch, has_mispredict, dec_ready,
    input  stall_fetch, bundle_vld_to_dec, pc_to_dec, inst_to_dec,
           recv_pc_to_dec, pred_to_dec, lane_vld_to_dec, occupancy, overflow_err
  );
endinterface

// File: rtl/fetch_bundle_queue.sv
// Decode-side FIFO of 4-wide fetch bundles, flushed on ROB mispredict.
// Latency: a bundle pushed in cycle N is presented to decode in cycle N+1 (no bypass).
// Backpressure: registered stall_fetch with STALL_MARGIN slack; bundles arriving when full are dropped and flagged.
// Ports: clk, rst (sync, active-high), bus (slave side of fetch_bundle_queue_if).
module fetch_bundle_queue #(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 2,
  parameter int PC_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_bundle_queue_if.slave    bus
);
  localparam int LW = 4 * PC_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_THR = CW'(DEPTH - STALL_MARGIN);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STALL_MARGIN < 1 || STALL_MARGIN >= DEPTH) begin : g_bad_params
    $error("fetch_bundle_queue: illegal DEPTH/STALL_MARGIN");
  end

  typedef struct packed {
    logic [LW-1:0] pc;
    logic [LW-1:0] inst;
    logic [LW-1:0] recv_pc;
    logic [3:0]    pred;
  } bundle_t;

  bundle_t       mem [DEPTH];
  bundle_t       head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          stall_q;
  logic          overflow_q;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [3:0]    lane_vld;

  assign full = (count == CNT_FULL);
  // A flush cycle swallows both sides of the handshake.
  assign pop  = (count != '0) && bus.dec_ready && !bus.has_mispredict;
  // Full is still writable when the head leaves in the same cycle.
  assign push = bus.fetch_vld && (!full || pop) && !bus.has_mispredict;
  assign drop = bus.fetch_vld && full && !pop && !bus.has_mispredict;

  always_comb begin
    count_next = count;
    if (bus.has_mispredict) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count   <= count_next;
      // Stall looks at the post-update count so fetch sees it one cycle earlier.
      stall_q <= (count_next >= STALL_THR);
      if (bus.has_mispredict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc:      bus.pc_from_fetch,
                       inst:    bus.inst_from_fetch,
                       recv_pc: bus.recv_pc_from_fetch,
                       pred:    bus.pred_from_fetch};
    end
  end

  assign head = mem[rd_ptr];

  // A lane holding an all-zero instruction is a NOP filler.
  always_comb begin
    lane_vld = '0;
    for (int i = 0; i < 4; i++) begin
      lane_vld[i] = (count != '0) && (head.inst[i*PC_WIDTH +: PC_WIDTH] != '0);
    end
  end

  assign bus.stall_fetch       = stall_q;
  assign bus.bundle_vld_to_dec = (count != '0);
  assign bus.pc_to_dec         = head.pc;
  assign bus.inst_to_dec       = head.inst;
  assign bus.recv_pc_to_dec    = head.recv_pc;
  assign bus.pred_to_dec       = head.pred;
  assign bus.lane_vld_to_dec   = lane_vld;
  assign bus.occupancy         = count;
  assign bus.overflow_err      = overflow_q;
endmodule
